outpkt_checksum_interval: RTL and testbench

- Next-generation output-packet checksum inserter. It sits between packet-builder output and the output FIFO/USB path.
- Passes 16-bit packet words through with valid/ready-style FIFO handshakes on both sides.
- Inserts an inverted 32-bit checksum after the packet header, after every INTERVAL_WORDS data words, and after the final data word.
- Header length, interval and interval-enable are parametrised.

---
 rtl/outpkt_checksum_interval.sv | 205 ++++++++++++++++++++
 tb/tb_outpkt_checksum_interval.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/outpkt_checksum_interval.sv
// Purpose: passes 16-bit packet words through and inserts an inverted 32-bit checksum after the header, every INTERVAL_WORDS data words, and at packet end.
// Latency: a word accepted at cycle N appears on dout at N+2 when the output register is free; 1 word/cycle sustained.
// Backpressure: rd_en low freezes the FSM and the output register; full rises while the input register cannot drain, so wr_en stalls losslessly.
module outpkt_checksum_interval #(
  parameter int HEADER_WORDS   = 5,
  parameter int INTERVAL_WORDS = 224,
  parameter bit INTERVAL_EN    = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] din,
  input  logic        pkt_new,
  input  logic        pkt_end,
  input  logic        wr_en,
  output logic        full,
  output logic [15:0] dout,
  output logic        pkt_end_out,
  input  logic        rd_en,
  output logic        empty
);

  // Counter only ever has to reach the longer of the two segment lengths minus one.
  localparam int MAX_W = (HEADER_WORDS > INTERVAL_WORDS) ? HEADER_WORDS : INTERVAL_WORDS;
  localparam int CW    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CW-1:0] HDR_LAST = CW'(HEADER_WORDS - 1);
  localparam logic [CW-1:0] INT_LAST = CW'(INTERVAL_WORDS - 1);

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    FOLD   = 2'd1,
    CKS_LO = 2'd2,
    CKS_HI = 2'd3
  } state_t;

  typedef enum logic {
    HEADER = 1'b0,
    DATA   = 1'b1
  } phase_t;

  // Input register
  logic        in_vld;
  logic [15:0] in_dat;
  logic        in_new;
  logic        in_end;

  // Output register
  logic        out_vld;

  // Checksum / sequencing state
  state_t      state;
  phase_t      phase;
  logic [CW-1:0] cnt;
  logic [31:0] sum;
  logic [15:0] lo_word;      // first word of a pair, waiting for its partner
  logic        pair_flag;    // lo_word holds an unpaired word
  logic        seg_pkt_end;  // current segment was closed by pkt_end

  // Handshake and datapath decode
  logic        out_ok;
  logic        drain;
  logic        accept;
  logic        first_half;
  logic        seg_end;
  logic        out_wr;
  logic [15:0] out_wdat;
  logic        out_wend;

  assign out_ok     = ~out_vld | rd_en;
  assign drain      = (state == PASS) & in_vld & out_ok;
  assign full       = in_vld & ~drain;
  assign accept     = wr_en & ~full;
  assign empty      = ~out_vld;
  // A packet start always begins a fresh pair, which realigns a malformed stream.
  assign first_half = in_new | ~pair_flag;

  // Segment boundary for the word currently sitting in the input register.
  always_comb begin
    seg_end = 1'b0;
    if (phase == HEADER) begin
      seg_end = (cnt == HDR_LAST);
    end else begin
      seg_end = in_end | (INTERVAL_EN && (cnt == INT_LAST));
    end
  end

  // Select what, if anything, is written into the output register this cycle.
  always_comb begin
    out_wr   = 1'b0;
    out_wdat = in_dat;
    out_wend = 1'b0;
    if (drain) begin
      out_wr   = 1'b1;
      out_wdat = in_dat;
    end else if ((state == CKS_LO) && out_ok) begin
      out_wr   = 1'b1;
      out_wdat = ~sum[15:0];
    end else if ((state == CKS_HI) && out_ok) begin
      out_wr   = 1'b1;
      out_wdat = ~sum[31:16];
      out_wend = seg_pkt_end;
    end
  end

  // Input register: refills in the same cycle it drains.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      in_vld <= 1'b0;
      in_dat <= 16'h0;
      in_new <= 1'b0;
      in_end <= 1'b0;
    end else if (accept) begin
      in_vld <= 1'b1;
      in_dat <= din;
      in_new <= pkt_new;
      in_end <= pkt_end;
    end else if (drain) begin
      in_vld <= 1'b0;
    end
  end

  // Output register: a write and a read in the same cycle keep it occupied.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_vld     <= 1'b0;
      dout        <= 16'h0;
      pkt_end_out <= 1'b0;
    end else if (out_wr) begin
      out_vld     <= 1'b1;
      dout        <= out_wdat;
      pkt_end_out <= out_wend;
    end else if (rd_en) begin
      out_vld     <= 1'b0;
      pkt_end_out <= 1'b0;
    end
  end

  // Sequencer: accumulate pairs while passing words, then fold and emit the checksum.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= PASS;
      phase       <= HEADER;
      cnt         <= '0;
      sum         <= 32'h0;
      lo_word     <= 16'h0;
      pair_flag   <= 1'b0;
      seg_pkt_end <= 1'b0;
    end else begin
      case (state)
        PASS: begin
          if (drain) begin
            if (first_half) begin
              lo_word   <= in_dat;
              pair_flag <= 1'b1;
              if (in_new) begin
                sum <= 32'h0;
              end
            end else begin
              sum       <= sum + {in_dat, lo_word};
              pair_flag <= 1'b0;
            end
            if (seg_end) begin
              cnt         <= '0;
              // pkt_end on a header word has no effect; header length governs.
              seg_pkt_end <= (phase == DATA) & in_end;
              state       <= first_half ? FOLD : CKS_LO;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        FOLD: begin
          // Trailing odd word counts as a zero-extended pair.
          sum       <= sum + {16'h0, lo_word};
          pair_flag <= 1'b0;
          state     <= CKS_LO;
        end

        CKS_LO: begin
          if (out_ok) begin
            state <= CKS_HI;
          end
        end

        CKS_HI: begin
          if (out_ok) begin
            sum       <= 32'h0;
            pair_flag <= 1'b0;
            if (phase == HEADER) begin
              phase <= DATA;
            end else if (seg_pkt_end) begin
              phase <= HEADER;
            end else begin
              phase <= DATA;
            end
            state <= PASS;
          end
        end

        default: state <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_outpkt_checksum_interval.sv
// Purpose: scoreboard bench for outpkt_checksum_interval with interval and no-interval instances.
// Latency: expected words are queued before each packet is sent; a monitor pops on every consumed output.
// Backpressure: rd_en is either held high, randomly toggled, or held low to fill the pipeline.
module tb_outpkt_checksum_interval;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [15:0] din [2];
  logic        pkt_new [2];
  logic        pkt_end [2];
  logic        wr_en [2];
  logic        full [2];
  logic [15:0] dout [2];
  logic        pkt_end_out [2];
  logic        rd_en [2];
  logic        empty [2];

  int checks = 0;
  int errors = 0;
  int rd_mode = 0;  // 0: read always, 1: random reads, 2: no reads

  logic [16:0] exp0[$];
  logic [16:0] exp1[$];
  logic [16:0] lst[$];
  logic [15:0] hq[$];
  logic [15:0] dq[$];
  logic [16:0] e0;
  logic [16:0] e1;

  always #5 CLK = ~CLK;

  outpkt_checksum_interval #(
    .HEADER_WORDS(5), .INTERVAL_WORDS(4), .INTERVAL_EN(1'b1)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .din(din[0]), .pkt_new(pkt_new[0]),
    .pkt_end(pkt_end[0]), .wr_en(wr_en[0]), .full(full[0]), .dout(dout[0]),
    .pkt_end_out(pkt_end_out[0]), .rd_en(rd_en[0]), .empty(empty[0])
  );

  outpkt_checksum_interval #(
    .HEADER_WORDS(5), .INTERVAL_WORDS(4), .INTERVAL_EN(1'b0)
  ) dut_noint (
    .CLK(CLK), .RESET_N(RESET_N), .din(din[1]), .pkt_new(pkt_new[1]),
    .pkt_end(pkt_end[1]), .wr_en(wr_en[1]), .full(full[1]), .dout(dout[1]),
    .pkt_end_out(pkt_end_out[1]), .rd_en(rd_en[1]), .empty(empty[1])
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, req);
    end
  endtask

  // Reference checksum: little-endian pairs summed mod 2^32, odd word zero-extended, inverted.
  function automatic logic [31:0] cks(input logic [15:0] s[$]);
    logic [31:0] acc;
    acc = 32'h0;
    for (int i = 0; i < s.size(); i += 2) begin
      if (i + 1 < s.size()) acc = acc + {s[i+1], s[i]};
      else                  acc = acc + {16'h0, s[i]};
    end
    return ~acc;
  endfunction

  task automatic push_exp(input int k, input logic [15:0] d, input logic e);
    if (k == 0) exp0.push_back({e, d});
    else        exp1.push_back({e, d});
  endtask

  task automatic push_list(input int k);
    foreach (lst[i]) begin
      if (k == 0) exp0.push_back(lst[i]);
      else        exp1.push_back(lst[i]);
    end
  endtask

  // Expected stream for the interval instance (INTERVAL_WORDS=4).
  task automatic model_pkt();
    logic [15:0] seg[$];
    logic [31:0] c;
    foreach (hq[i]) push_exp(0, hq[i], 1'b0);
    c = cks(hq);
    push_exp(0, c[15:0], 1'b0);
    push_exp(0, c[31:16], 1'b0);
    foreach (dq[i]) begin
      push_exp(0, dq[i], 1'b0);
      seg.push_back(dq[i]);
      if ((i == dq.size() - 1) || (seg.size() == 4)) begin
        c = cks(seg);
        push_exp(0, c[15:0], 1'b0);
        push_exp(0, c[31:16], i == dq.size() - 1);
        seg.delete();
      end
    end
  endtask

  task automatic send(input int k, input logic [15:0] w, input logic n, input logic e);
    int budget;
    budget = 1000;
    din[k] = w; pkt_new[k] = n; pkt_end[k] = e; wr_en[k] = 1'b1;
    while (budget > 0) begin
      @(negedge CLK);
      if (!full[k]) break;
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut%0d word %h still full", k, w);
    end
    @(posedge CLK);
    #1;
    wr_en[k] = 1'b0; pkt_new[k] = 1'b0; pkt_end[k] = 1'b0;
  endtask

  task automatic gap(input bit thr);
    if (thr) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge CLK);
        #1;
      end
    end
  endtask

  task automatic send_pkt(input int k, input bit thr);
    foreach (hq[i]) begin
      gap(thr);
      send(k, hq[i], i == 0, 1'b0);
    end
    foreach (dq[i]) begin
      gap(thr);
      send(k, dq[i], 1'b0, i == dq.size() - 1);
    end
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && b < 5000) begin
      @(posedge CLK);
      b++;
    end
    check("drain_q0", exp0.size(), 0);
    check("drain_q1", exp1.size(), 0);
    @(posedge CLK);
    #1;
  endtask

  // Read strobe generation, changed just after each active edge.
  always @(posedge CLK) begin
    #1;
    rd_en[0] = (rd_mode == 1) ? 1'($urandom_range(0, 1)) : (rd_mode == 0);
    rd_en[1] = 1'b1;
  end

  // Monitors: every word consumed at the next edge is compared with the queue head.
  always @(negedge CLK) begin
    if (RESET_N === 1'b1 && rd_en[0] === 1'b1 && empty[0] === 1'b0) begin
      if (exp0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out0_extra got %h end %b expected nothing", dout[0], pkt_end_out[0]);
      end else begin
        e0 = exp0.pop_front();
        check("out0_word", {15'h0, pkt_end_out[0], dout[0]}, {15'h0, e0});
      end
    end
  end

  always @(negedge CLK) begin
    if (RESET_N === 1'b1 && rd_en[1] === 1'b1 && empty[1] === 1'b0) begin
      if (exp1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out1_extra got %h end %b expected nothing", dout[1], pkt_end_out[1]);
      end else begin
        e1 = exp1.pop_front();
        check("out1_word", {15'h0, pkt_end_out[1], dout[1]}, {15'h0, e1});
      end
    end
  end

  initial begin
    RESET_N = 1'b1;
    for (int k = 0; k < 2; k++) begin
      din[k] = 16'h0; pkt_new[k] = 1'b0; pkt_end[k] = 1'b0; wr_en[k] = 1'b0; rd_en[k] = 1'b1;
    end
    #2 RESET_N = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_full", full[k], 0);
      check("rst_empty", empty[k], 1);
      check("rst_pkt_end_out", pkt_end_out[k], 0);
      check("rst_dout", dout[k], 0);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK) RESET_N = 1'b1;
    @(posedge CLK);
    #1;

    // Header with odd fold, then an all-ones data pair that inverts to zero.
    hq = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    dq = '{16'hFFFF, 16'hFFFF};
    lst = '{17'h00001, 17'h00002, 17'h00003, 17'h00004, 17'h00005, 17'h0FFF6, 17'h0FFF9,
            17'h0FFFF, 17'h0FFFF, 17'h00000, 17'h10000};
    push_list(0);
    send_pkt(0, 1'b0);

    // Carry out of bit 31 is dropped; 4 data words also land on the interval boundary.
    dq = '{16'hFFFF, 16'hFFFF, 16'h0002, 16'h0000};
    lst = '{17'h00001, 17'h00002, 17'h00003, 17'h00004, 17'h00005, 17'h0FFF6, 17'h0FFF9,
            17'h0FFFF, 17'h0FFFF, 17'h00002, 17'h00000, 17'h0FFFE, 17'h1FFFF};
    push_list(0);
    send_pkt(0, 1'b0);

    // Intermediate checksum after 4 data words, final after 6.
    dq = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
    lst = '{17'h00001, 17'h00002, 17'h00003, 17'h00004, 17'h00005, 17'h0FFF6, 17'h0FFF9,
            17'h00001, 17'h00001, 17'h00001, 17'h00001, 17'h0FFFD, 17'h0FFFD,
            17'h00001, 17'h00001, 17'h0FFFE, 17'h1FFFE};
    push_list(0);
    send_pkt(0, 1'b0);

    // Same packet with intervals disabled: a single checksum at the end.
    lst = '{17'h00001, 17'h00002, 17'h00003, 17'h00004, 17'h00005, 17'h0FFF6, 17'h0FFF9,
            17'h00001, 17'h00001, 17'h00001, 17'h00001, 17'h00001, 17'h00001,
            17'h0FFFC, 17'h1FFFC};
    push_list(1);
    send_pkt(1, 1'b0);
    wait_drain();

    // Throttled traffic on both sides against the reference model.
    rd_mode = 1;
    for (int p = 0; p < 50; p++) begin
      hq.delete();
      dq.delete();
      for (int i = 0; i < 5; i++) hq.push_back(16'($urandom));
      for (int i = 0; i < $urandom_range(1, 9); i++) dq.push_back(16'($urandom));
      model_pkt();
      send_pkt(0, 1'b1);
    end
    wait_drain();
    rd_mode = 0;
    repeat (2) begin
      @(posedge CLK);
      #1;
    end

    // Fill the pipeline mid data segment, then reset.
    hq = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    lst = '{17'h00001, 17'h00002, 17'h00003, 17'h00004, 17'h00005, 17'h0FFF6, 17'h0FFF9,
            17'h00007};
    push_list(0);
    foreach (hq[i]) send(0, hq[i], i == 0, 1'b0);
    send(0, 16'h0007, 1'b0, 1'b0);
    wait_drain();
    rd_mode = 2;
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    send(0, 16'h0AAA, 1'b0, 1'b0);
    send(0, 16'h0BBB, 1'b0, 1'b0);
    check("pre_rst_full", full[0], 1);
    check("pre_rst_empty", empty[0], 0);
    #2 RESET_N = 1'b0;
    #1;
    check("mid_rst_full", full[0], 0);
    check("mid_rst_empty", empty[0], 1);
    check("mid_rst_pkt_end_out", pkt_end_out[0], 0);
    exp0.delete();
    @(negedge CLK) RESET_N = 1'b1;
    rd_mode = 0;
    repeat (2) begin
      @(posedge CLK);
      #1;
    end

    // Fresh packet after reset: checksums start from zero.
    hq = '{16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000};
    dq = '{16'h0010, 16'h0020, 16'h0030};
    lst = '{17'h01000, 17'h02000, 17'h03000, 17'h04000, 17'h05000, 17'h06FFF, 17'h09FFF,
            17'h00010, 17'h00020, 17'h00030, 17'h0FFBF, 17'h1FFDF};
    push_list(0);
    send_pkt(0, 1'b0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
